// File: rtl/spectro_pkg.sv
// Shared constants and write-FSM state type for the spectrogram column ring buffer.
package spectro_pkg;

    localparam int DEF_DATA_W = 10;
    localparam int DEF_BIN_AW = 5;
    localparam int DEF_COL_AW = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        FROZEN = 2'd2
    } spectro_state_e;

endpackage

// File: rtl/spectro_sdp_mem.sv
// Simple dual-port RAM: registered read-before-write port with zero-fill mask.
// SPECTRO_RD_OUTREG_EN adds a second output register (read latency 2).
module spectro_sdp_mem #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic              rzero_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Non-blocking read of mem_q returns the pre-write word on an address collision.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= re_i;
            if (re_i) begin
                rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
            end
        end
    end

`ifdef SPECTRO_RD_OUTREG_EN
    logic              rvalid2_q;
    logic [DATA_W-1:0] rdata2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid2_q <= 1'b0;
            rdata2_q  <= '0;
        end else begin
            rvalid2_q <= rvalid_q;
            if (rvalid_q) begin
                rdata2_q <= rdata_q;
            end
        end
    end

    assign rvalid_o = rvalid2_q;
    assign rdata_o  = rdata2_q;
`else
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
`endif

endmodule

// File: rtl/spectro_col_ring_buffer.sv
// Ring of the last 2^COL_AW spectrum columns with freeze/drain, length checking and zero-fill.
// Build option: SPECTRO_RD_OUTREG_EN adds one cycle of read latency (output register).
module spectro_col_ring_buffer
    import spectro_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BIN_AW = DEF_BIN_AW,
    parameter int COL_AW = DEF_COL_AW
) (
    input  logic              clk,
    input  logic              rst,
    // Write stream: a beat transfers on a cycle where wr_valid and wr_ready are both high;
    // wr_ready never depends on wr_valid, and the source holds data until the transfer.
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              freeze,
    input  logic              rd_en,
    input  logic [COL_AW-1:0] rd_col,
    input  logic [BIN_AW-1:0] rd_bin,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [COL_AW:0]   col_count,
    output logic              col_done,
    output logic              len_err,
    output spectro_state_e    dbg_state
);

    localparam logic [BIN_AW-1:0] BIN_MAX = '1;

    spectro_state_e    state_q, state_d;
    logic [BIN_AW-1:0] bin_cnt_q, bin_cnt_d;
    logic [COL_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [COL_AW:0]   col_count_q, col_count_d;
    logic              col_done_q, col_done_d;
    logic              len_err_q, len_err_d;

    logic              accept;
    logic              at_end;
    logic              commit;
    logic              abort;

    assign wr_ready = !rst && (state_q != FROZEN);
    assign accept   = wr_valid && wr_ready;
    assign at_end   = (bin_cnt_q == BIN_MAX);
    assign commit   = accept && at_end;
    assign abort    = accept && wr_last && !at_end;

    always_comb begin
        bin_cnt_d   = bin_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        col_count_d = col_count_q;
        col_done_d  = commit;
        len_err_d   = len_err_q || (commit && !wr_last) || abort;
        if (commit) begin
            bin_cnt_d = '0;
            wr_ptr_d  = wr_ptr_q + 1'b1;
            // MSB set means the count already equals 2^COL_AW.
            if (!col_count_q[COL_AW]) begin
                col_count_d = col_count_q + 1'b1;
            end
        end else if (abort) begin
            bin_cnt_d = '0;
        end else if (accept) begin
            bin_cnt_d = bin_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d = (bin_cnt_q == '0) ? FROZEN : DRAIN;
                end
            end
            DRAIN: begin
                if (!freeze) begin
                    state_d = RUN;
                end else if (commit || abort) begin
                    state_d = FROZEN;
                end
            end
            FROZEN: begin
                if (!freeze) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            bin_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            col_count_q <= '0;
            col_done_q  <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_cnt_q   <= bin_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            col_count_q <= col_count_d;
            col_done_q  <= col_done_d;
            len_err_q   <= len_err_d;
        end
    end

    logic [COL_AW-1:0] oldest;
    logic [COL_AW-1:0] rd_phys;
    logic              rd_zero;

    // Until the ring has filled, physical slot 0 is the oldest column.
    assign oldest  = col_count_q[COL_AW] ? wr_ptr_q : '0;
    assign rd_phys = oldest + rd_col;
    assign rd_zero = ({1'b0, rd_col} >= col_count_q);

    spectro_sdp_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (COL_AW + BIN_AW)
    ) u_mem (
        .clk_i    (clk),
        .rst_i    (rst),
        .we_i     (accept),
        .waddr_i  ({wr_ptr_q, bin_cnt_q}),
        .wdata_i  (wr_data),
        .re_i     (rd_en),
        .raddr_i  ({rd_phys, rd_bin}),
        .rzero_i  (rd_zero),
        .rvalid_o (rd_valid),
        .rdata_o  (rd_data)
    );

    assign col_count = col_count_q;
    assign col_done  = col_done_q;
    assign len_err   = len_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spectro_col_ring_buffer.sv
// Directed bench for spectro_col_ring_buffer with a column-level reference model checked every cycle.
module tb_spectro_col_ring_buffer;
  import spectro_pkg::*;

  localparam int DATA_W = 10;
  localparam int BIN_AW = 5;
  localparam int COL_AW = 4;
  localparam int NB = 32;
  localparam int NC = 16;
`ifdef SPECTRO_RD_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int M_RUN = 0;
  localparam int M_DRAIN = 1;
  localparam int M_FROZEN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic wr_last = 1'b0;
  logic freeze = 1'b0;
  logic rd_en = 1'b0;
  logic [COL_AW-1:0] rd_col = '0;
  logic [BIN_AW-1:0] rd_bin = '0;
  logic rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [COL_AW:0] col_count;
  logic col_done;
  logic len_err;
  spectro_state_e dbg_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spectro_col_ring_buffer dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .freeze(freeze),
    .rd_en(rd_en), .rd_col(rd_col), .rd_bin(rd_bin),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .col_count(col_count), .col_done(col_done), .len_err(len_err),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory indexed by (ring slot, bin), plus column-level bookkeeping.
  int m_mem [0:NC-1][0:NB-1];
  int m_st, m_bcnt, m_wptr, m_cnt;
  int m_done, m_err;
  int s1_v, s1_d, o_v, o_d;

  task automatic model_reset();
    m_st = M_RUN; m_bcnt = 0; m_wptr = 0; m_cnt = 0;
    m_done = 0; m_err = 0;
    s1_v = 0; s1_d = 0; o_v = 0; o_d = 0;
  endtask

  task automatic model_step();
    int oldest, phys, old_b;
    bit acc, end_col, ab;
    if (LAT == 2) begin
      o_v = s1_v;
      if (s1_v != 0) o_d = s1_d;
    end
    s1_v = rd_en ? 1 : 0;
    if (rd_en) begin
      oldest = (m_cnt < NC) ? 0 : m_wptr;
      phys = (oldest + int'(rd_col)) % NC;
      s1_d = (int'(rd_col) >= m_cnt) ? 0 : m_mem[phys][int'(rd_bin)];
    end
    acc = wr_valid && (m_st != M_FROZEN);
    old_b = m_bcnt;
    end_col = acc && (old_b == NB - 1);
    ab = acc && wr_last && (old_b != NB - 1);
    m_done = end_col ? 1 : 0;
    if (acc) begin
      m_mem[m_wptr][old_b] = int'(wr_data);
      if (end_col) begin
        m_bcnt = 0;
        m_wptr = (m_wptr + 1) % NC;
        if (m_cnt < NC) m_cnt++;
        if (!wr_last) m_err = 1;
      end else if (wr_last) begin
        m_bcnt = 0;
        m_err = 1;
      end else begin
        m_bcnt++;
      end
    end
    case (m_st)
      M_RUN:   if (freeze) m_st = (old_b == 0) ? M_FROZEN : M_DRAIN;
      M_DRAIN: if (!freeze) m_st = M_RUN; else if (end_col || ab) m_st = M_FROZEN;
      default: if (!freeze) m_st = M_RUN;
    endcase
  endtask

  initial begin
    for (int c = 0; c < NC; c++)
      for (int b = 0; b < NB; b++)
        m_mem[c][b] = 0;
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
      if (rst) model_reset();
      chk("wr_ready", wr_ready, (!rst && m_st != M_FROZEN) ? 1 : 0);
      chk("col_count", col_count, m_cnt);
      chk("col_done", col_done, m_done);
      chk("len_err", len_err, m_err);
      chk("rd_valid", rd_valid, (LAT == 2) ? o_v : s1_v);
      chk("rd_data", rd_data, (LAT == 2) ? o_d : s1_d);
      if (!rst) chk("frozen_state", (dbg_state == FROZEN) ? 1 : 0, (m_st == M_FROZEN) ? 1 : 0);
    end
  end

  // Driver tasks: each starts and ends 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input int d, input bit last);
    wr_valid = 1'b1;
    wr_data = DATA_W'(d % 1024);
    wr_last = last;
    idle(1);
    wr_valid = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic write_col(input int base, input bit with_last);
    for (int b = 0; b < NB; b++) beat(base + b, with_last && (b == NB - 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic rd(input int col, input int bin, input bit do_wr, input int wd,
                    input int exp, input string name);
    rd_en = 1'b1;
    rd_col = COL_AW'(col);
    rd_bin = BIN_AW'(bin);
    if (do_wr) begin
      wr_valid = 1'b1;
      wr_data = DATA_W'(wd);
      wr_last = 1'b0;
    end
    idle(1);
    rd_en = 1'b0;
    wr_valid = 1'b0;
    if (LAT == 2) begin
      chk({name, "_early"}, rd_valid, 0);
      idle(1);
    end
    chk({name, "_valid"}, rd_valid, 1);
    chk({name, "_data"}, rd_data, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", wr_ready, 0);
    chk("reset_rd_data", rd_data, 0);
    rst = 1'b0;

    // First column: data = bin index
    write_col(0, 1'b1);
    chk("s1_done", col_done, 1);
    chk("s1_count", col_count, 1);
    rd(0, 5, 1'b0, 0, 5, "s1_rd");

    // Fill to 20 columns: ring wraps, oldest is column 4
    for (int k = 1; k < 20; k++) write_col(k * 32, 1'b1);
    chk("wrap_count", col_count, 16);
    chk("wrap_model_wptr", m_wptr, 4);
    rd(0, 0, 1'b0, 0, 128, "wrap_oldest");
    rd(15, 31, 1'b0, 0, 639, "wrap_newest");

    // Reset mid-column, then zero-fill with two columns
    do_reset();
    for (int b = 0; b < 10; b++) beat(900 + b, 1'b0);
    do_reset();
    write_col(0, 1'b1);
    write_col(32, 1'b1);
    chk("zf_count", col_count, 2);
    rd(3, 0, 1'b0, 0, 0, "zf_col3");
    rd(2, 5, 1'b0, 0, 0, "zf_col2");
    rd(1, 2, 1'b0, 0, 34, "zf_col1");

    // Freeze with drain
    for (int b = 0; b < 10; b++) beat(64 + b, 1'b0);
    freeze = 1'b1;
    for (int b = 10; b < NB; b++) beat(64 + b, b == NB - 1);
    chk("drain_ready", wr_ready, 0);
    chk("drain_count", col_count, 3);
    chk("drain_done", col_done, 1);
    beat(777, 1'b0);
    chk("frozen_ready", wr_ready, 0);
    freeze = 1'b0;
    idle(1);
    chk("unfreeze_ready", wr_ready, 1);
    freeze = 1'b1;
    idle(1);
    chk("freeze_idle_ready", wr_ready, 0);
    freeze = 1'b0;
    idle(1);
    rd(2, 9, 1'b0, 0, 73, "drain_rd");

    // Early wr_last aborts; missing wr_last still commits
    for (int b = 0; b < 8; b++) beat(500 + b, b == 7);
    chk("abort_err", len_err, 1);
    chk("abort_count", col_count, 3);
    write_col(300, 1'b0);
    chk("nolast_count", col_count, 4);
    chk("nolast_err", len_err, 1);
    rd(3, 0, 1'b0, 0, 300, "abort_bin0");
    rd(3, 7, 1'b0, 0, 307, "abort_bin7");
    rd(3, 31, 1'b0, 0, 331, "abort_bin31");

    // Fill the ring, then collide a read and a write on slot 0 bin 1
    for (int k = 4; k < 16; k++) write_col(k * 32, 1'b1);
    chk("full_count", col_count, 16);
    chk("full_model_wptr", m_wptr, 0);
    beat(999, 1'b0);
    rd(0, 1, 1'b1, 888, 1, "rbw_old");
    rd(0, 1, 1'b0, 0, 888, "rbw_new");

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spectro_col_ring_buffer.md
Name: spectro_col_ring_buffer

Overview:
- Parametrised successor to the fixed 512x10 spectrogram dual-port RAM.
- Stores the last 2^COL_AW spectrum columns of 2^BIN_AW bins each in a ring. Each column is one FFT magnitude frame.
- Accepts columns on a valid/ready write stream from the FFT/magnitude stage. Serves random-access reads to the display scanout, using a logical column index where 0 is the oldest column.
- Adds behaviour the old RAM lacks: ring wrap, freeze with column drain, column-length checking, and zero-fill of columns not yet written.

Parameters:
- DATA_W, 10, bit width of one bin magnitude.
- BIN_AW, 5, log2 of bins per column (32).
- COL_AW, 4, log2 of columns held (16). Memory depth is 2^(COL_AW+BIN_AW).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active high.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  block accepts a beat this cycle.
- wr_data  in  DATA_W  bin magnitude.
- wr_last  in  1  marks the final bin of a column.
- freeze  in  1  request to stop accepting columns; display holds its image.
- rd_en  in  1  read request.
- rd_col  in  COL_AW  logical column, 0 = oldest.
- rd_bin  in  BIN_AW  bin index.
- rd_valid  out  1  rd_data is valid.
- rd_data  out  DATA_W  read result.
- col_count  out  COL_AW+1  number of committed columns, saturating at 2^COL_AW.
- col_done  out  1  one-cycle pulse after each column commit.
- len_err  out  1  sticky wr_last mismatch flag.

Behaviour:
- Reset values:
  - State RUN; bin_cnt=0; wr_ptr=0.
  - col_count=0, col_done=0, len_err=0, rd_valid=0, rd_data=0.
  - wr_ready=0 while rst is high, 1 on the first cycle after release.
  - Memory contents are not reset.
- Write acceptance and address:
  - A beat is accepted when wr_valid and wr_ready are both high.
  - Write address = {wr_ptr, bin_cnt}. bin_cnt increments on each accepted beat.
- Column commit (accepted beat with bin_cnt = 2^BIN_AW-1):
  - bin_cnt returns to 0.
  - wr_ptr increments mod 2^COL_AW.
  - col_count increments, saturating at 2^COL_AW.
  - col_done pulses the following cycle.
  - If wr_last was low on this beat, len_err is set and the column still commits.
- Early wr_last (accepted beat with wr_last=1 and bin_cnt < 2^BIN_AW-1):
  - Column is aborted: bin_cnt returns to 0, wr_ptr and col_count are unchanged.
  - len_err is set.
- Write FSM:
  - RUN: wr_ready=1. freeze=1 with bin_cnt=0 goes to FROZEN. freeze=1 with bin_cnt>0 goes to DRAIN.
  - DRAIN: wr_ready=1; the current column continues. A commit or abort goes to FROZEN. freeze=0 goes back to RUN, continuing the column.
  - FROZEN: wr_ready=0. freeze=0 goes to RUN on the next cycle.
  - If a commit and freeze=0 occur in the same DRAIN cycle, the next state is RUN.
- Read mapping:
  - oldest = (col_count < 2^COL_AW) ? 0 : wr_ptr.
  - Physical column = (oldest + rd_col) mod 2^COL_AW.
  - The mapping is sampled in the rd_en cycle.
- Read timing and results:
  - rd_valid and rd_data appear 1 cycle after rd_en.
  - If rd_col >= col_count, rd_data=0 with rd_valid=1.
  - rd_data holds its value when rd_en=0.
- A read and a write to the same address in one cycle return the old data (read-before-write).
- len_err clears only on rst.
- Reset asserted mid-column discards the partial column.

Optional Feature:
- Macro: SPECTRO_RD_OUTREG_EN.
- Defined: an extra output register stage is added; rd_valid and rd_data arrive 2 cycles after rd_en.
- Undefined: read latency is 1 cycle.
- Zero-fill and read-before-write rules are unchanged in both builds.

Decomposition:
- Package spectro_pkg holds:
  - the FSM state enum (RUN, DRAIN, FROZEN);
  - default DATA_W, BIN_AW and COL_AW constants.
- One sub-module, spectro_sdp_mem:
  - simple dual-port inferred RAM on clk;
  - 1-cycle registered read, read-before-write;
  - optional output register controlled by the macro.

Test Plan:
- Reset, then write column 0 with data = bin index and wr_last on bin 31. Expect col_done one cycle after the commit and col_count=1. Then rd_col=0, rd_bin=5: expect rd_data=5 and rd_valid=1 one cycle later.
- Write 20 columns, column k holding (k*32+bin) mod 1024. Expect col_count=16 and wr_ptr=4. rd_col=0, rd_bin=0: expect 128. rd_col=15, rd_bin=31: expect 639.
- With col_count=2, read rd_col=3: expect rd_data=0 and rd_valid=1.
- Assert freeze after 10 beats of a column. Expect 22 more beats accepted, then wr_ready=0 and col_count+1. Deassert freeze: expect wr_ready=1 on the next cycle. Assert freeze at bin_cnt=0: expect wr_ready=0 on the next cycle.
- wr_last on bin 7: expect len_err=1, col_count unchanged, and the next beat written to bin 0 of the same wr_ptr. Omit wr_last on bin 31: expect the column committed and len_err to stay 1.
- With SPECTRO_RD_OUTREG_EN defined, rerun the first scenario: expect rd_valid 2 cycles after rd_en. Also issue a read and a write to the same address in one cycle: expect the old value.
